// File: rtl/pool_readout_pkg.sv
// Shared constants and FSM encoding for the layer-1 pool readout block.
package pool_readout_pkg;

    localparam int unsigned L1_WORDS = 1024;
    localparam int unsigned DATA_W   = 20;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned IDX_W    = 10;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L1_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCap  = 2'b01,
        StOut  = 2'b10,
        StDone = 2'b11
    } state_e;

    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == LAST_IDX;
    endfunction

endpackage

// File: rtl/pool_readout_max_tracker.sv
// Running maximum of the accepted words; ties keep the earliest index.
module max_tracker
    import pool_readout_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              update_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [DATA_W-1:0] max_val_o,
    output logic [IDX_W-1:0]  max_idx_o
);

    logic [DATA_W-1:0] max_val_d, max_val_q;
    logic [IDX_W-1:0]  max_idx_d, max_idx_q;

    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (clear_i) begin
            max_val_d = '0;
            max_idx_d = '0;
        end else if (update_i && (data_i > max_val_q)) begin
            // Strict compare so an equal later word never moves the index.
            max_val_d = data_i;
            max_idx_d = idx_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_val_o = max_val_q;
    assign max_idx_o = max_idx_q;

endmodule

// File: rtl/pool_readout.sv
// Streams the 1024-word layer-1 map from layer memory over a valid/ready port,
// one word per two cycles, while tracking the largest word and its index.
module pool_readout
    import pool_readout_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic [2:0]        csel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_addr,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  max_idx
);

    state_e            state_d, state_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              crd_d, crd_q;
    logic [ADDR_W-1:0] caddr_d, caddr_q;
    logic [2:0]        csel_d, csel_q;
    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    logic [IDX_W-1:0]  out_addr_d, out_addr_q;

    logic              max_clear;
    logic              max_update;

    assign max_clear  = (state_q == StIdle) && start;
    assign max_update = (state_q == StOut) && out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        crd_d       = 1'b0;
        caddr_d     = caddr_q;
        csel_d      = csel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    caddr_d = '0;
                    crd_d   = 1'b1;
                    csel_d  = CSEL_L1;
                    busy_d  = 1'b1;
                    state_d = StCap;
                end
            end
            StCap: begin
                // Read data for the address issued last cycle is valid at this edge.
                out_data_d  = cdata_rd;
                out_addr_d  = caddr_q[IDX_W-1:0];
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (is_last_idx(out_addr_q)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        caddr_d = caddr_q + ADDR_W'(1);
                        crd_d   = 1'b1;
                        state_d = StCap;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                csel_d  = CSEL_NONE;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crd_q       <= 1'b0;
            caddr_q     <= '0;
            csel_q      <= CSEL_NONE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            crd_q       <= crd_d;
            caddr_q     <= caddr_d;
            csel_q      <= csel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

    max_tracker u_max_tracker (
        .clk_i     (clk),
        .rst_i     (reset),
        .clear_i   (max_clear),
        .update_i  (max_update),
        .data_i    (out_data_q),
        .idx_i     (out_addr_q),
        .max_val_o (max_val),
        .max_idx_o (max_idx)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign crd       = crd_q;
    assign caddr_rd  = caddr_q;
    assign csel      = csel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_pool_readout.sv
// Self-checking bench for pool_readout: vector table of map patterns plus
// hand-written backpressure, mid-run reset and ignored-restart sequences.
module tb_pool_readout;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [9:0]  out_addr;
    logic [19:0] max_val;
    logic [9:0]  max_idx;

    pool_readout dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .max_val   (max_val),
        .max_idx   (max_idx)
    );

    always #5 clk = ~clk;

    // Layer memory: data for the registered address is valid by the next edge.
    logic [19:0] mem [1024];
    assign cdata_rd = crd ? mem[caddr_rd[9:0]] : 20'hBAD00;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_start;
    int t_done;
    int first_valid;
    int done_cnt;
    bit mon_en = 1'b0;
    logic [9:0]  q_addr [$];
    logic [19:0] q_data [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired, got timeout want event (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                q_addr.push_back(out_addr);
                q_data.push_back(out_data);
            end
            if (out_valid && first_valid < 0) first_valid = cyc - t_start;
            if (done) done_cnt++;
            if (crd) check("crd_csel", 32'(csel), 32'(3'b011));
            if (!busy) check("idle_csel", 32'(csel), 32'(3'b000));
            if (out_valid) check("crd_in_out", 32'(crd), 0);
            check("caddr_range", 32'(caddr_rd <= 12'd1023), 1);
        end
    end

    task automatic fill(input int pat);
        for (int i = 0; i < 1024; i++) begin
            case (pat)
                0: mem[i] = 20'(i);
                1: mem[i] = (i == 5 || i == 700) ? 20'hFFFFF : 20'h00100;
                2: mem[i] = 20'h0;
                3: mem[i] = 20'hFFFFF - 20'(i);
                4: mem[i] = 20'($urandom);
                default: mem[i] = 20'($urandom_range(3));
            endcase
        end
    endtask

    // Reference: the largest word, then the lowest index holding it.
    task automatic ref_max(output logic [19:0] m, output logic [9:0] idx);
        m = '0;
        for (int i = 0; i < 1024; i++) if (mem[i] > m) m = mem[i];
        idx = '0;
        for (int i = 1023; i >= 0; i--) if (mem[i] == m) idx = 10'(i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_crd"},       32'(crd), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_csel"},      32'(csel), 0);
        check({tag, "_caddr"},     32'(caddr_rd), 0);
        check({tag, "_out_data"},  32'(out_data), 0);
        check({tag, "_out_addr"},  32'(out_addr), 0);
        check({tag, "_max_val"},   32'(max_val), 0);
        check({tag, "_max_idx"},   32'(max_idx), 0);
    endtask

    task automatic start_run();
        q_addr.delete();
        q_data.delete();
        done_cnt    = 0;
        first_valid = -1;
        @(posedge clk);
        #1 start = 1'b1;
        out_ready = 1'b1;
        t_start   = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_max_clear", 32'(max_val), 0);
        check("start_busy", 32'(busy), 1);
    endtask

    task automatic wait_beat(input int addr);
        bit seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            if (out_valid && out_addr == 10'(addr)) seen = 1'b1;
        end
        if (!seen) fail_timeout("wait_beat");
    endtask

    task automatic finish_stream(input int pct);
        bit seen = 1'b0;
        for (int n = 0; n < 8000 && !seen; n++) begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (done) begin
                seen   = 1'b1;
                t_done = cyc - t_start;
            end
        end
        if (!seen) fail_timeout("done_wait");
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
    endtask

    task automatic check_stream(input string tag);
        int errs = 0;
        check({tag, "_beats"}, 32'(q_addr.size()), 1024);
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] !== 10'(i) || q_data[i] !== mem[i]) errs++;
        end
        check({tag, "_order_errs"}, 32'(errs), 0);
        check({tag, "_done_pulses"}, 32'(done_cnt), 1);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    typedef struct {
        int         pat;
        int         ready_pct;
        bit         use_model;
        logic [19:0] exp_max;
        logic [9:0]  exp_idx;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [19:0] em;
        logic [9:0]  ei;

        vecs[0] = '{pat: 0, ready_pct: 100, use_model: 1'b0, exp_max: 20'd1023,  exp_idx: 10'd1023};
        vecs[1] = '{pat: 1, ready_pct: 100, use_model: 1'b0, exp_max: 20'hFFFFF, exp_idx: 10'd5};
        vecs[2] = '{pat: 2, ready_pct: 100, use_model: 1'b0, exp_max: 20'h0,     exp_idx: 10'd0};
        vecs[3] = '{pat: 3, ready_pct: 70,  use_model: 1'b0, exp_max: 20'hFFFFF, exp_idx: 10'd0};
        vecs[4] = '{pat: 4, ready_pct: 60,  use_model: 1'b1, exp_max: 20'h0,     exp_idx: 10'd0};
        vecs[5] = '{pat: 5, ready_pct: 100, use_model: 1'b1, exp_max: 20'h0,     exp_idx: 10'd0};

        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        fill(0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].pat);
            em = vecs[v].exp_max;
            ei = vecs[v].exp_idx;
            if (vecs[v].use_model) ref_max(em, ei);
            start_run();
            finish_stream(vecs[v].ready_pct);
            check_stream($sformatf("vec%0d", v));
            check($sformatf("vec%0d_max_val", v), 32'(max_val), 32'(em));
            check($sformatf("vec%0d_max_idx", v), 32'(max_idx), 32'(ei));
            if (vecs[v].ready_pct == 100) begin
                check($sformatf("vec%0d_first_valid", v), 32'(first_valid), 2);
                check($sformatf("vec%0d_done_lat", v), 32'(t_done <= 2050), 1);
            end
        end

        // Backpressure on beat 17 for ten cycles.
        fill(0);
        start_run();
        wait_beat(16);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data",  32'(out_data), 32'(mem[17]));
            check("bp_addr",  32'(out_addr), 17);
            check("bp_crd",   32'(crd), 0);
            check("bp_caddr", 32'(caddr_rd), 17);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        t_done = cyc;
        wait_beat(18);
        check("bp_resume_lat", 32'(cyc - t_done), 2);
        finish_stream(100);
        check_stream("bp");
        check("bp_max_idx", 32'(max_idx), 1023);

        // Asynchronous reset in the middle of beat 300.
        fill(0);
        start_run();
        wait_beat(300);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid_no_done", 32'(done_cnt), 0);
        check("mid_idle", 32'(busy), 0);
        fill(4);
        ref_max(em, ei);
        start_run();
        finish_stream(100);
        check_stream("after_rst");
        check("after_rst_first_valid", 32'(first_valid), 2);
        check("after_rst_max_val", 32'(max_val), 32'(em));
        check("after_rst_max_idx", 32'(max_idx), 32'(ei));

        // A second start mid-run must be ignored.
        fill(5);
        ref_max(em, ei);
        start_run();
        wait_beat(50);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_stream(100);
        check_stream("restart");
        check("restart_max_val", 32'(max_val), 32'(em));
        check("restart_max_idx", 32'(max_idx), 32'(ei));

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool_readout.md
POOL_READOUT -- requirements
Module: pool_readout

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 start  input  1  one-cycle request to stream the layer-1 map; sampled only in IDLE.
REQ-004 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-005 done  output  1  one-cycle pulse when the last word has been accepted downstream.
REQ-006 crd  output  1  layer-memory read enable.
REQ-007 caddr_rd  output  12  layer-memory read address; only 0..1023 is used.
REQ-008 cdata_rd  input  20  layer-memory read data, valid on the rising edge one cycle after crd/caddr_rd are driven.
REQ-009 csel  output  3  layer-memory select: 3'b011 (layer 1) while active, 3'b000 otherwise.
REQ-010 out_valid  output  1  out_data/out_addr hold a word.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid && out_ready at a rising edge.
REQ-012 out_data  output  20  layer-1 word, unsigned Q4.16.
REQ-013 out_addr  output  10  index 0..1023 of out_data.
REQ-014 max_val  output  20  largest word streamed in the current or last run.
REQ-015 max_idx  output  10  index of max_val.

Function
REQ-016 The FSM SHALL have states IDLE, CAP, OUT, DONE. All outputs SHALL be registered.
REQ-017 IDLE: on start=1, the block SHALL set caddr_rd=0, crd=1, csel=3'b011, max_val=0, max_idx=0, and busy=1, then go to CAP.
REQ-018 CAP: the block SHALL capture cdata_rd into out_data, set out_addr=caddr_rd[9:0], crd=0, out_valid=1, then go to OUT.
REQ-019 OUT with out_ready=0: the block SHALL hold out_valid, out_data, out_addr, caddr_rd, max_val, and max_idx stable, with crd=0.
REQ-020 OUT with out_ready=1: the block SHALL update the statistics.
  - If out_data > max_val (unsigned, strict), set max_val=out_data and max_idx=out_addr.
  - Clear out_valid.
  - If out_addr==1023, go to DONE.
  - Otherwise set caddr_rd=caddr_rd+1 and crd=1, then go to CAP.
REQ-021 Throughput SHALL be one word per 2 cycles with out_ready held high. The first out_valid SHALL be 2 cycles after the start edge.
REQ-022 DONE: the block SHALL assert done for exactly one cycle, set busy=0 and csel=3'b000, then go to IDLE.
REQ-023 max_val and max_idx SHALL hold after DONE until the next accepted start.
REQ-024 start while not in IDLE SHALL be ignored, with no restart and no counter change.
REQ-025 Ties SHALL keep the earliest index. An all-zero map SHALL yield max_val=0 and max_idx=0.
REQ-026 caddr_rd SHALL never exceed 1023. The index SHALL NOT wrap to 0 within a run.
REQ-027 crd=1 SHALL imply csel=3'b011. crd SHALL never be high in OUT, DONE, or IDLE.

Reset
REQ-028 On reset: state=IDLE; busy, done, crd, out_valid = 0; csel=3'b000; caddr_rd, out_data, out_addr, max_val, max_idx = 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse. The next start SHALL restart from address 0.

Structure
REQ-030 A shared package SHALL hold:
  - CSEL_NONE=3'b000, CSEL_L0=3'b001, CSEL_L1=3'b011.
  - L1_WORDS=1024, DATA_W=20, ADDR_W=12.
  - The FSM state encoding.
REQ-031 A single sub-module, max_tracker (compare/update of max_val/max_idx, clear on start), is natural. Everything else SHALL stay in pool_readout.

Verification
REQ-032 Memory word[i]=i, out_ready=1, start pulse:
  - required: 1024 beats with out_data=i and out_addr=i in order;
  - required: done within 2050 cycles of start, max_val=1023, max_idx=1023.
REQ-033 Backpressure, out_ready=0 for 10 cycles at beat 17:
  - required: out_data=word[17] and out_addr=17 stable, crd=0 throughout;
  - required: beat 18 follows 2 cycles after release.
REQ-034 All words 20'h00100 except word[5]=word[700]=20'hFFFFF:
  - required: max_val=20'hFFFFF, max_idx=5.
REQ-035 Reset at beat 300:
  - required: all outputs at REQ-028 values, no done pulse;
  - required: a new start streams from out_addr=0.
REQ-036 Second start pulsed at beat 50:
  - required: stream continues 51..1023 with a single done pulse.
REQ-037 Every cycle, the bench SHALL check:
  - crd implies csel=3'b011;
  - csel=3'b000 in IDLE;
  - caddr_rd ≤ 1023.
